// File: rtl/auto_ramp_seq_if.sv
// Command/status bundle between the AUTO motion sequencer and its controller.
// The controller drives the move request and step feedback; the sequencer drives the drive outputs.
interface auto_ramp_seq_if #(
  parameter int unsigned WIDTH_TR  = 16,
  parameter int unsigned WIDTH_CNT = 16
);
  logic                 start;
  logic                 stop;
  logic                 dir_cmd;
  logic [WIDTH_CNT-1:0] steps_target;
  logic [WIDTH_TR-1:0]  period_start;
  logic [WIDTH_TR-1:0]  period_min;
  logic [WIDTH_TR-1:0]  period_step;
  logic                 step_pulse;
  logic                 enable_AUTO;
  logic                 dir_AUTO;
  logic [WIDTH_TR-1:0]  period_AUTO;
  logic                 busy;
  logic                 done;
  logic [WIDTH_CNT-1:0] steps_done;

  modport master (
    output start, stop, dir_cmd, steps_target, period_start, period_min, period_step,
           step_pulse,
    input  enable_AUTO, dir_AUTO, period_AUTO, busy, done, steps_done
  );

  modport slave (
    input  start, stop, dir_cmd, steps_target, period_start, period_min, period_step,
           step_pulse,
    output enable_AUTO, dir_AUTO, period_AUTO, busy, done, steps_done
  );
endinterface

// File: rtl/auto_ramp_seq.sv
// AUTO-mode trapezoidal motion sequencer: accelerate, cruise, decelerate so the move lands
// on an exact step count, with a controlled early-stop path.
module auto_ramp_seq #(
  parameter int unsigned WIDTH_TR  = 16,
  parameter int unsigned WIDTH_CNT = 16
) (
  input logic             clk,
  input logic             rst,
  auto_ramp_seq_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StAccel, StCruise, StDecel, StDone} state_e;

  state_e               state_q, state_d;
  logic                 dir_q, dir_d;
  logic [WIDTH_TR-1:0]  period_q, period_d;
  logic [WIDTH_TR-1:0]  p_start_q, p_start_d;
  logic [WIDTH_TR-1:0]  p_min_q, p_min_d;
  logic [WIDTH_TR-1:0]  p_step_q, p_step_d;
  logic [WIDTH_CNT-1:0] steps_done_q, steps_done_d;
  logic [WIDTH_CNT-1:0] target_eff_q, target_eff_d;
  logic [WIDTH_CNT-1:0] ramp_len_q, ramp_len_d;
  logic                 enable_q, enable_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Saturating period neighbours, computed one bit wider so carry/borrow is visible.
  logic [WIDTH_TR:0]    period_sum, period_diff;
  logic [WIDTH_TR-1:0]  period_up, period_down;
  logic [WIDTH_CNT-1:0] steps_inc, rem;

  always_comb begin
    period_sum  = {1'b0, period_q} + {1'b0, p_step_q};
    period_diff = {1'b0, period_q} - {1'b0, p_step_q};
    period_up   = (period_sum > {1'b0, p_start_q}) ? p_start_q : period_sum[WIDTH_TR-1:0];
    period_down = (period_diff[WIDTH_TR] || (period_diff < {1'b0, p_min_q})) ?
                  p_min_q : period_diff[WIDTH_TR-1:0];
    steps_inc   = steps_done_q + WIDTH_CNT'(1);
    rem         = target_eff_q - steps_inc;
  end

  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    period_d     = period_q;
    p_start_d    = p_start_q;
    p_min_d      = p_min_q;
    p_step_d     = p_step_q;
    steps_done_d = steps_done_q;
    target_eff_d = target_eff_q;
    ramp_len_d   = ramp_len_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          dir_d        = bus.dir_cmd;
          p_start_d    = bus.period_start;
          p_min_d      = bus.period_min;
          p_step_d     = bus.period_step;
          target_eff_d = bus.steps_target;
          steps_done_d = '0;
          ramp_len_d   = '0;
          period_d     = bus.period_start;
          if (bus.steps_target == '0) begin
            state_d = StDone;
          end else if (bus.period_start <= bus.period_min) begin
            state_d = StCruise;
          end else begin
            state_d = StAccel;
          end
        end
      end

      StAccel, StCruise: begin
        if (bus.stop) begin
          // A coincident step is counted first, then the stop distance is measured from it.
          if (bus.step_pulse) begin
            steps_done_d = steps_inc;
          end
          if ((ramp_len_q == '0) || (bus.step_pulse && (rem == '0))) begin
            state_d = StDone;
          end else begin
            if (bus.step_pulse) begin
              period_d     = period_up;
              target_eff_d = steps_inc + ramp_len_q;
            end else begin
              target_eff_d = steps_done_q + ramp_len_q;
            end
            state_d = StDecel;
          end
        end else if (bus.step_pulse) begin
          steps_done_d = steps_inc;
          if (rem == '0) begin
            state_d = StDone;
          end else if (rem <= ramp_len_q) begin
            period_d = period_up;
            state_d  = StDecel;
          end else if (state_q == StAccel) begin
            ramp_len_d = ramp_len_q + WIDTH_CNT'(1);
            period_d   = period_down;
            if (period_down == p_min_q) begin
              state_d = StCruise;
            end
          end
        end
      end

      StDecel: begin
        if (bus.step_pulse) begin
          steps_done_d = steps_inc;
          period_d     = period_up;
          if (steps_inc == target_eff_q) begin
            state_d = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    enable_d = (state_d == StAccel) || (state_d == StCruise) || (state_d == StDecel);
    busy_d   = enable_d;
    done_d   = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      dir_q        <= 1'b0;
      period_q     <= '0;
      p_start_q    <= '0;
      p_min_q      <= '0;
      p_step_q     <= '0;
      steps_done_q <= '0;
      target_eff_q <= '0;
      ramp_len_q   <= '0;
      enable_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      period_q     <= period_d;
      p_start_q    <= p_start_d;
      p_min_q      <= p_min_d;
      p_step_q     <= p_step_d;
      steps_done_q <= steps_done_d;
      target_eff_q <= target_eff_d;
      ramp_len_q   <= ramp_len_d;
      enable_q     <= enable_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.enable_AUTO = enable_q;
  assign bus.dir_AUTO    = dir_q;
  assign bus.period_AUTO = period_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.steps_done  = steps_done_q;

endmodule

// File: tb/tb_auto_ramp_seq.sv
// Directed bench for auto_ramp_seq: trapezoid, short move, early stops, degenerate inputs,
// ignored requests and mid-move reset, all against hand-computed periods and counts.
module tb_auto_ramp_seq;

  logic clk;
  logic rst;

  int unsigned n_checks;
  int unsigned n_fail;

  auto_ramp_seq_if #(.WIDTH_TR(16), .WIDTH_CNT(16)) bus ();

  auto_ramp_seq #(
    .WIDTH_TR  (16),
    .WIDTH_CNT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int unsigned en, input int unsigned bsy,
                           input int unsigned dn, input int unsigned per,
                           input int unsigned sd);
    check_eq({tag, ".enable"}, int'(bus.enable_AUTO), en);
    check_eq({tag, ".busy"}, int'(bus.busy), bsy);
    check_eq({tag, ".done"}, int'(bus.done), dn);
    check_eq({tag, ".period"}, int'(bus.period_AUTO), per);
    check_eq({tag, ".steps"}, int'(bus.steps_done), sd);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_move(input logic dir, input logic [15:0] tgt, input logic [15:0] ps,
                            input logic [15:0] pm, input logic [15:0] pst);
    bus.dir_cmd      = dir;
    bus.steps_target = tgt;
    bus.period_start = ps;
    bus.period_min   = pm;
    bus.period_step  = pst;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
  endtask

  task automatic step();
    bus.step_pulse = 1'b1;
    tick();
    bus.step_pulse = 1'b0;
  endtask

  task automatic step_with_stop();
    bus.step_pulse = 1'b1;
    bus.stop       = 1'b1;
    tick();
    bus.step_pulse = 1'b0;
    bus.stop       = 1'b0;
  endtask

  int unsigned per_full[10]  = '{100, 80, 60, 40, 40, 40, 40, 60, 80, 100};
  int unsigned per_short[4]  = '{100, 80, 60, 80};
  int unsigned per_estop[5]  = '{100, 80, 60, 40, 40};
  int unsigned per_after[3]  = '{40, 60, 80};

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b0;
    bus.start        = 1'b0;
    bus.stop         = 1'b0;
    bus.dir_cmd      = 1'b0;
    bus.steps_target = '0;
    bus.period_start = '0;
    bus.period_min   = '0;
    bus.period_step  = '0;
    bus.step_pulse   = 1'b0;
    tick();
    tick();
    check_out("reset", 0, 0, 0, 0, 0);
    check_eq("reset.dir", int'(bus.dir_AUTO), 0);
    rst = 1'b1;
    tick();

    // Full trapezoid
    start_move(1'b1, 16'd10, 16'd100, 16'd40, 16'd20);
    check_out("full.start", 1, 1, 0, 100, 0);
    check_eq("full.dir", int'(bus.dir_AUTO), 1);
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("full.per%0d", k + 1), int'(bus.period_AUTO), per_full[k]);
      check_eq($sformatf("full.en%0d", k + 1), int'(bus.enable_AUTO), 1);
      step();
    end
    check_out("full.done", 0, 0, 1, 100, 10);
    tick();
    check_out("full.idle", 0, 0, 0, 100, 10);
    check_eq("full.dir_hold", int'(bus.dir_AUTO), 1);

    // Short move: never cruises
    start_move(1'b0, 16'd4, 16'd100, 16'd40, 16'd20);
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("short.per%0d", k + 1), int'(bus.period_AUTO), per_short[k]);
      step();
    end
    check_out("short.done", 0, 0, 1, 100, 4);
    check_eq("short.dir", int'(bus.dir_AUTO), 0);
    tick();

    // Early stop from cruise with ramp_len = 3
    start_move(1'b0, 16'd100, 16'd100, 16'd40, 16'd20);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("estop.per%0d", k + 1), int'(bus.period_AUTO), per_estop[k]);
      step();
    end
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check_out("estop.stop", 1, 1, 0, 40, 5);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("estop.per%0d", k + 6), int'(bus.period_AUTO), per_after[k]);
      step();
    end
    check_out("estop.done", 0, 0, 1, 100, 8);
    tick();

    // Stop on the second step: counted first, ramp_len = 1 so one more step
    start_move(1'b0, 16'd100, 16'd100, 16'd40, 16'd20);
    step();
    step_with_stop();
    check_out("stop2.coinc", 1, 1, 0, 100, 2);
    step();
    check_out("stop2.done", 0, 0, 1, 100, 3);
    tick();

    // Stop on the step taken at period 60 (ramp_len = 2): period 60 -> 80, two more steps
    start_move(1'b0, 16'd100, 16'd100, 16'd40, 16'd20);
    step();
    step();
    check_eq("stop3.pre", int'(bus.period_AUTO), 60);
    step_with_stop();
    check_out("stop3.coinc", 1, 1, 0, 80, 3);
    step();
    check_out("stop3.step4", 1, 1, 0, 100, 4);
    step();
    check_out("stop3.done", 0, 0, 1, 100, 5);
    tick();

    // Zero-step move
    start_move(1'b1, 16'd0, 16'd100, 16'd40, 16'd20);
    check_out("zero.done", 0, 0, 1, 100, 0);
    tick();
    check_out("zero.idle", 0, 0, 0, 100, 0);

    // Flat profile: start period equals floor
    start_move(1'b0, 16'd3, 16'd50, 16'd50, 16'd20);
    check_out("flat.start", 1, 1, 0, 50, 0);
    step();
    step();
    check_out("flat.step2", 1, 1, 0, 50, 2);
    step();
    check_out("flat.done", 0, 0, 1, 50, 3);
    tick();

    // Start during a move is ignored, then reset mid-accel
    start_move(1'b1, 16'd20, 16'd100, 16'd40, 16'd20);
    step();
    start_move(1'b0, 16'd0, 16'd500, 16'd10, 16'd1);
    check_out("ign.start", 1, 1, 0, 80, 1);
    check_eq("ign.dir", int'(bus.dir_AUTO), 1);
    rst = 1'b0;
    tick();
    check_out("rst.mid", 0, 0, 0, 0, 0);
    check_eq("rst.dir", int'(bus.dir_AUTO), 0);
    rst = 1'b1;
    tick();
    check_out("rst.after", 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
